// File: rtl/prog_seq.sv
// Program sequencer: increment / conditional jump / call / return with a hardware return stack.
// Optional halt support is enabled by defining PROG_SEQ_HALT_EN.
module prog_seq #(
  parameter int unsigned         ADDR_W      = 8,
  parameter int unsigned         STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]   RESET_VEC   = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall,
  input  logic                               is_jump,
  input  logic [2:0]                         jump_cond,
  input  logic                               is_call,
  input  logic                               is_ret,
  input  logic [ADDR_W-1:0]                  target,
  input  logic                               flag_z,
  input  logic                               flag_s,
  input  logic                               flag_o,
`ifdef PROG_SEQ_HALT_EN
  input  logic                               is_halt,
  output logic                               halted,
`endif
  output logic [ADDR_W-1:0]                  addr,
  output logic [$clog2(STACK_DEPTH):0]       depth,
  output logic                               stk_full,
  output logic                               stk_empty,
  output logic                               err_ovf,
  output logic                               err_unf
);

  localparam int unsigned SW = $clog2(STACK_DEPTH);
  localparam int unsigned DW = SW + 1;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0] seq;
  logic              cond_ok;
  logic              run;
  logic              push;
  logic [SW-1:0]     push_idx;
  logic [SW-1:0]     top_idx;
  logic              full;
  logic              empty;

  assign seq      = addr_q + ADDR_W'(1);
  assign full     = (depth_q == DW'(STACK_DEPTH));
  assign empty    = (depth_q == '0);
  assign push_idx = SW'(depth_q);
  assign top_idx  = SW'(depth_q - DW'(1));

`ifdef PROG_SEQ_HALT_EN
  logic halted_q, halted_d;

  // A sampled halt freezes everything, including this cycle's addr.
  always_comb begin
    halted_d = halted_q;
    run      = 1'b0;
    if (!stall && !halted_q) begin
      if (is_halt) halted_d = 1'b1;
      else         run      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end

  assign halted = halted_q;
`else
  assign run = !stall;
`endif

  always_comb begin
    cond_ok = 1'b0;
    case (jump_cond)
      3'd0:    cond_ok = 1'b1;
      3'd1:    cond_ok = flag_z;
      3'd2:    cond_ok = !flag_z;
      3'd3:    cond_ok = flag_s;
      3'd4:    cond_ok = !flag_s;
      3'd5:    cond_ok = flag_o;
      3'd6:    cond_ok = !flag_o;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (run) begin
      if (is_ret) begin
        if (!empty) begin
          addr_d  = stack_q[top_idx];
          depth_d = depth_q - DW'(1);
        end else begin
          addr_d = seq;
          unf_d  = 1'b1;
        end
      end else if (is_call) begin
        if (!full) begin
          push    = 1'b1;
          addr_d  = target;
          depth_d = depth_q + DW'(1);
        end else begin
          addr_d = seq;
          ovf_d  = 1'b1;
        end
      end else if (is_jump) begin
        addr_d = cond_ok ? target : seq;
      end else begin
        addr_d = seq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= RESET_VEC;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage needs no reset: entries at or above depth are never read.
  always_ff @(posedge clk) begin
    if (!rst && push) stack_q[push_idx] <= seq;
  end

  assign addr      = addr_q;
  assign depth     = depth_q;
  assign stk_full  = full;
  assign stk_empty = empty;
  assign err_ovf   = ovf_q;
  assign err_unf   = unf_q;

endmodule

// File: tb/tb_prog_seq.sv
// Self-checking bench for prog_seq (default parameters) against a queue-based reference model.
module tb_prog_seq;

  logic       clk;
  logic       rst, stall, is_jump, is_call, is_ret;
  logic [2:0] jump_cond;
  logic [7:0] target;
  logic       flag_z, flag_s, flag_o;
  logic [7:0] addr;
  logic [2:0] depth;
  logic       stk_full, stk_empty, err_ovf, err_unf;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] m_addr;
  logic [7:0] m_stack[$];
  logic       m_ovf, m_unf;

  prog_seq #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_VEC(8'h00)) dut (
    .clk(clk), .rst(rst), .stall(stall), .is_jump(is_jump), .jump_cond(jump_cond),
    .is_call(is_call), .is_ret(is_ret), .target(target),
    .flag_z(flag_z), .flag_s(flag_s), .flag_o(flag_o),
    .addr(addr), .depth(depth), .stk_full(stk_full), .stk_empty(stk_empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic taken(input logic [2:0] c, input logic z, s, o);
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return s;
      3'd4: return !s;
      3'd5: return o;
      3'd6: return !o;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    if (rst) begin
      m_addr = 8'h00; m_stack.delete(); m_ovf = 0; m_unf = 0;
    end else if (!stall) begin
      if (is_ret) begin
        if (m_stack.size() > 0) m_addr = m_stack.pop_back();
        else begin m_addr = m_addr + 8'd1; m_unf = 1; end
      end else if (is_call) begin
        if (m_stack.size() < 4) begin m_stack.push_back(m_addr + 8'd1); m_addr = target; end
        else begin m_addr = m_addr + 8'd1; m_ovf = 1; end
      end else if (is_jump && taken(jump_cond, flag_z, flag_s, flag_o)) m_addr = target;
      else m_addr = m_addr + 8'd1;
    end
  endtask

  function automatic logic [14:0] exp_vec();
    int d = m_stack.size();
    return {m_addr, 3'(d), (d == 4), (d == 0), m_ovf, m_unf};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {addr, depth, stk_full, stk_empty, err_ovf, err_unf};
  endfunction

  task automatic cycle(input logic r, st, j, input logic [2:0] jc, input logic c, rt,
                       input logic [7:0] tg, input logic [2:0] zso);
    rst = r; stall = st; is_jump = j; jump_cond = jc; is_call = c; is_ret = rt;
    target = tg; {flag_z, flag_s, flag_o} = zso;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();             cycle(0,0,0,3'd0,0,0,8'h00,3'b000); endtask
  task automatic do_reset();         cycle(1,0,0,3'd0,0,0,8'h00,3'b000); endtask
  task automatic go(input logic [7:0] a); cycle(0,0,1,3'd0,0,0,a,3'b000); endtask
  task automatic call(input logic [7:0] a); cycle(0,0,0,3'd0,1,0,a,3'b000); endtask
  task automatic ret();              cycle(0,0,0,3'd0,0,1,8'h00,3'b000); endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (dut_vec() !== 15'({8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0})) begin
      n_fail++; $display("FAIL reset: got %h want %h", dut_vec(), 15'({8'h00,3'd0,1'b0,1'b1,2'b00}));
    end
    for (int i = 1; i <= 5; i++) begin
      idle();
      n_vec++;
      if (addr !== 8'(i) || depth !== 3'd0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
        n_fail++; $display("FAIL idle_%0d: addr %h depth %0d ovf %b unf %b want addr %h", i, addr, depth, err_ovf, err_unf, 8'(i));
      end
    end
  endtask

  task automatic test_seq_wrap();
    go(8'hFE);
    idle();
    n_vec++;
    if (addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_ff: got %h want ff", addr); end
    idle();
    n_vec++;
    if (addr !== 8'h00) begin n_fail++; $display("FAIL wrap_00: got %h want 00", addr); end
  endtask

  task automatic test_jump();
    go(8'h10);
    cycle(0,0,1,3'd2,0,0,8'h40,3'b000);
    n_vec++;
    if (addr !== 8'h40) begin n_fail++; $display("FAIL jnz_taken: got %h want 40", addr); end
    go(8'h10);
    cycle(0,0,1,3'd2,0,0,8'h40,3'b100);
    n_vec++;
    if (addr !== 8'h11) begin n_fail++; $display("FAIL jnz_not_taken: got %h want 11", addr); end
    go(8'h10);
    cycle(0,0,1,3'd7,0,0,8'h40,3'b111);
    n_vec++;
    if (addr !== 8'h11) begin n_fail++; $display("FAIL jnever: got %h want 11", addr); end
  endtask

  task automatic test_nested_calls();
    logic [7:0] exp_ret [3];
    exp_ret[0] = 8'h31; exp_ret[1] = 8'h21; exp_ret[2] = 8'h06;
    do_reset();
    go(8'h05);
    call(8'h20); call(8'h30); call(8'h50);
    n_vec++;
    if (addr !== 8'h50 || depth !== 3'd3) begin
      n_fail++; $display("FAIL call3: addr %h depth %0d want 50/3", addr, depth);
    end
    for (int i = 0; i < 3; i++) begin
      ret();
      n_vec++;
      if (addr !== exp_ret[i] || depth !== 3'(2 - i)) begin
        n_fail++; $display("FAIL ret_%0d: addr %h depth %0d want %h/%0d", i, addr, depth, exp_ret[i], 2 - i);
      end
    end
  endtask

  task automatic test_stack_errors();
    do_reset();
    for (int i = 0; i < 4; i++) call(8'(8'h10 * (i + 1)));
    n_vec++;
    if (stk_full !== 1'b1 || depth !== 3'd4) begin
      n_fail++; $display("FAIL full: full %b depth %0d want 1/4", stk_full, depth);
    end
    go(8'h60);
    call(8'h99);
    n_vec++;
    if (addr !== 8'h61 || err_ovf !== 1'b1 || depth !== 3'd4 || err_unf !== 1'b0) begin
      n_fail++; $display("FAIL ovf: addr %h ovf %b unf %b depth %0d want 61/1/0/4", addr, err_ovf, err_unf, depth);
    end
    for (int i = 0; i < 4; i++) ret();
    go(8'h80);
    ret();
    n_vec++;
    if (addr !== 8'h81 || err_unf !== 1'b1 || depth !== 3'd0 || stk_empty !== 1'b1) begin
      n_fail++; $display("FAIL unf: addr %h unf %b depth %0d empty %b want 81/1/0/1", addr, err_unf, depth, stk_empty);
    end
    for (int i = 0; i < 3; i++) idle();
    n_vec++;
    if ({err_ovf, err_unf} !== 2'b11) begin n_fail++; $display("FAIL sticky: got %b want 11", {err_ovf, err_unf}); end
    do_reset();
    n_vec++;
    if ({err_ovf, err_unf} !== 2'b00) begin n_fail++; $display("FAIL err_clear: got %b want 00", {err_ovf, err_unf}); end
  endtask

  task automatic test_stall_priority();
    do_reset();
    call(8'h20);
    cycle(0,1,0,3'd0,1,0,8'h70,3'b000);
    n_vec++;
    if (addr !== 8'h20 || depth !== 3'd1) begin
      n_fail++; $display("FAIL stall_call: addr %h depth %0d want 20/1", addr, depth);
    end
    cycle(0,0,1,3'd0,1,1,8'h70,3'b000);
    n_vec++;
    if (addr !== 8'h01 || depth !== 3'd0) begin
      n_fail++; $display("FAIL ret_priority: addr %h depth %0d want 01/0", addr, depth);
    end
    cycle(0,1,0,3'd0,0,1,8'h00,3'b000);
    n_vec++;
    if (addr !== 8'h01 || err_unf !== 1'b0) begin
      n_fail++; $display("FAIL stall_ret: addr %h unf %b want 01/0", addr, err_unf);
    end
    call(8'h20);
    cycle(1,1,1,3'd0,1,1,8'h70,3'b000);
    n_vec++;
    if (addr !== 8'h00 || depth !== 3'd0) begin
      n_fail++; $display("FAIL rst_priority: addr %h depth %0d want 00/0", addr, depth);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            8'($urandom), 3'($urandom));
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1; stall = 0; is_jump = 0; jump_cond = 0; is_call = 0; is_ret = 0;
    target = 0; flag_z = 0; flag_s = 0; flag_o = 0;
    m_addr = 0; m_ovf = 0; m_unf = 0;
    test_reset();
    test_seq_wrap();
    test_jump();
    test_nested_calls();
    test_stack_errors();
    test_stall_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_seq.md
Name: prog_seq

Overview:
- Parametrised successor to the single-cycle program counter in the accumulator CPU.
- Generates the instruction address each cycle: increment, conditional jump, call and return.
- Adds a hardware return-address stack of configurable depth, a pipeline stall input and sticky stack-error flags.
- Sits between the decoder/flag register and program memory; `addr` drives the program-memory address directly.

Parameters:
- ADDR_W, 8, width of the instruction address and of the return-stack entries.
- STACK_DEPTH, 4, number of return-stack entries (power of two, at least 2).
- RESET_VEC, 0, value loaded into `addr` on reset (ADDR_W bits).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  when 1, all state is held for this cycle.
- is_jump  in  1  decoded jump instruction.
- jump_cond  in  3  0 always, 1 Z, 2 NZ, 3 S, 4 NS, 5 O, 6 NO, 7 never.
- is_call  in  1  decoded unconditional call.
- is_ret  in  1  decoded return.
- target  in  ADDR_W  jump or call destination.
- flag_z  in  1  zero flag.
- flag_s  in  1  sign flag.
- flag_o  in  1  overflow flag.
- addr  out  ADDR_W  current instruction address.
- depth  out  $clog2(STACK_DEPTH)+1  number of valid stack entries.
- stk_full  out  1  depth == STACK_DEPTH (combinational from depth).
- stk_empty  out  1  depth == 0 (combinational from depth).
- err_ovf  out  1  sticky: a call was attempted while the stack was full.
- err_unf  out  1  sticky: a return was attempted while the stack was empty.

Behaviour:
- Reset (rst=1 at an edge):
  - addr=RESET_VEC, depth=0, err_ovf=0, err_unf=0; stack contents are don't-care.
  - rst has priority over stall and over every control input, including a reset that arrives mid call or return.
- Stall: when stall=1 (and rst=0), addr, depth, stack and error flags are all held. Control inputs are ignored and no error flag is set.
- Next-address priority when not stalled: is_ret > is_call > is_jump > sequential. Lower-priority requests asserted in the same cycle are dropped.
- seq = addr+1, taken modulo 2^ADDR_W, so the maximum address wraps to 0.
- Return:
  - If depth>0: addr<=stack[depth-1], depth<=depth-1.
  - If depth==0: addr<=seq, err_unf<=1, depth stays 0.
- Call:
  - If depth<STACK_DEPTH: stack[depth]<=seq, depth<=depth+1, addr<=target.
  - If full: addr<=seq, err_ovf<=1, no push and no branch.
- Jump:
  - addr<=target when the condition holds, else addr<=seq.
  - Condition is evaluated on the flag values present in the same cycle.
  - Code 7 is never taken.
- Latency: one cycle. The new addr is visible after the edge that samples the control inputs.
- Error flags clear only on reset.
- Stack contents above depth are never read.

Optional Feature:
- Macro: PROG_SEQ_HALT_EN.
- With the macro defined:
  - Adds input is_halt (1 bit) and output halted (1 bit), reset value 0.
  - is_halt has the highest priority below rst and stall; when sampled, it sets halted<=1 and holds addr.
  - While halted=1, addr, depth and the error flags are frozen regardless of the other inputs; only rst clears halted.
- Without the macro: neither port exists, and behaviour is exactly as described in Behaviour.

Test Plan:
1. Reset then 5 idle cycles (ADDR_W=8, RESET_VEC=0) -> addr goes 0,1,2,3,4,5; depth=0; both error flags 0.
2. Sequential wrap: run addr to 8'hFF, then one idle cycle -> addr=8'h00.
3. Conditional jump:
   - addr=8'h10, is_jump=1, jump_cond=2, target=8'h40, flag_z=0 -> addr=8'h40.
   - Same stimulus with flag_z=1 -> addr=8'h11.
4. Nested calls then returns:
   - Calls at 8'h05 (target 8'h20), 8'h20 (target 8'h30), 8'h30 (target 8'h50) -> depth=3.
   - Three returns -> addr 8'h31, then 8'h21, then 8'h06; depth=0.
5. Stack errors (STACK_DEPTH=4):
   - Fifth call at addr 8'h60 -> addr=8'h61, err_ovf=1, depth stays 4.
   - Drain with 4 returns, then a fifth return at addr A -> addr=A+1, err_unf=1.
   - Both flags stay 1 until rst.
6. Stall and priority:
   - stall=1 with is_call=1 -> addr and depth unchanged, no push.
   - Then is_ret=1, is_call=1, is_jump=1 together with depth=1 -> the return is taken, depth=0.
   - rst asserted during that same cycle instead -> addr=RESET_VEC, depth=0.
